// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instru;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port: the fetch unit is the master, memory is the slave.
interface fetch_if;
  import fetch_pkg::*;

  // A request is accepted on a cycle where imem_req && imem_gnt; the master keeps
  // imem_req/imem_addr stable until accepted. Responses come back in request order,
  // one per imem_rvalid cycle, at least one cycle after their grant.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, credit-limited memory requests, prefetch
// queue and redirect handling feeding the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_if.master         imem,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instru,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_nextpc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop;
  logic [CW:0]     in_use;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_nextpc;
  logic            credit_ok;
  logic            grant;
  logic            rsp;
  logic            keep;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  // Queue slots are reserved at issue time, so a queued entry or an in-flight
  // request each hold one credit and the queue can never overflow.
  assign in_use    = {1'b0, count} + {1'b0, outstanding};
  assign credit_ok = in_use < (CW+1)'(DEPTH);

  assign imem.imem_req  = rst_n && !redirect && credit_ok;
  assign imem.imem_addr = fetch_pc;

  assign grant = imem.imem_req && imem.imem_gnt;
  // A response with nothing outstanding belongs to a transaction abandoned by reset.
  assign rsp   = imem.imem_rvalid && (outstanding != '0);
  assign keep  = rsp && (drop == '0) && !redirect;
  assign pop   = out_valid && !stall && !redirect;

  assign outstanding_nxt = outstanding + CW'(grant) - CW'(rsp);
  assign push_data       = '{pc: resp_pc, instru: imem.imem_rdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      hold_pc     <= '0;
      hold_nextpc <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
        drop     <= outstanding_nxt;
      end else begin
        if (grant)                  fetch_pc <= fetch_pc + PC_STEP;
        if (keep)                   resp_pc  <= resp_pc + PC_STEP;
        if (rsp && (drop != '0))    drop     <= drop - CW'(1);
      end
      if (out_valid) begin
        hold_pc     <= head.pc;
        hold_nextpc <= head.pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (keep),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign out_valid  = (count != '0);
  assign out_instru = out_valid ? head.instru          : NOP_INSTR;
  assign out_pc     = out_valid ? head.pc              : hold_pc;
  assign out_nextpc = out_valid ? head.pc + PC_STEP    : hold_nextpc;

endmodule
